// File: rtl/muldiv_ctrl_pkg.sv
// Shared defines for the HI/LO multiply/divide controller: op codes, FSM
// encoding and the stall / divider-start constants.
package muldiv_ctrl_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic Stop     = 1'b1;
  localparam logic NoStop   = 1'b0;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    MUL_RUN = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_ctrl_hilo_reg.sv
// Architectural HI/LO register pair. Define HILO_BYPASS_EN to make hi/lo
// show a value being written in the current cycle.
module hilo_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_wdata,
  input  logic [31:0] lo_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // HI/LO storage, cleared by reset; reset blocks any same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

`ifdef HILO_BYPASS_EN
  assign hi = hi_we ? hi_wdata : hi_q;
  assign lo = lo_we ? lo_wdata : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO-class op controller: sequences the external divider and pipelined
// multiplier, stalls the front end and owns HI/LO (see HILO_BYPASS_EN).
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        stallreq,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [3:0] LAST_CNT = 4'(MUL_LAT - 1);

  state_e      state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        sign_q, sign_d;
  logic [3:0]  cnt_q, cnt_d;

  logic in_idle, in_div, in_mul, in_done;
  logic issue, start_div, start_mul, wr_mthi, wr_mtlo;
  logic div_wait, div_fin, mul_last, mul_fin;
  logic hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  assign in_idle = (state_q == IDLE);
  assign in_div  = (state_q == DIV_RUN);
  assign in_mul  = (state_q == MUL_RUN);
  assign in_done = (state_q == DONE);

  assign issue     = in_idle && op_valid && !flush;
  assign start_div = issue && ((op == OP_DIV) || (op == OP_DIVU));
  assign start_mul = issue && ((op == OP_MULT) || (op == OP_MULTU));
  assign wr_mthi   = issue && !ex_stall && (op == OP_MTHI);
  assign wr_mtlo   = issue && !ex_stall && (op == OP_MTLO);

  // flush outranks a completing divide or the final multiply count
  assign div_wait = in_div && !flush && !div_ready;
  assign div_fin  = in_div && !flush && div_ready;
  assign mul_last = (cnt_q == LAST_CNT);
  assign mul_fin  = in_mul && !flush && mul_last;

  // Next-state and operand-latch decode
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_div) begin
          opa_d   = src1;
          opb_d   = src2;
          sign_d  = (op == OP_DIV);
          state_d = DIV_RUN;
        end else if (start_mul) begin
          opa_d   = src1;
          opb_d   = src2;
          sign_d  = (op == OP_MULT);
          cnt_d   = 4'd0;
          state_d = MUL_RUN;
        end else begin
          state_d = IDLE;
        end
      end
      DIV_RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else if (div_ready) begin
          state_d = DONE;
        end else begin
          state_d = DIV_RUN;
        end
      end
      MUL_RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mul_last) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (flush || !ex_stall) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, latched operands and multiply latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      sign_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hi_we    = !rst && (div_fin || mul_fin || wr_mthi);
  assign lo_we    = !rst && (div_fin || mul_fin || wr_mtlo);
  assign hi_wdata = div_fin ? div_result[63:32] : (mul_fin ? mul_result[63:32] : src1);
  assign lo_wdata = div_fin ? div_result[31:0]  : (mul_fin ? mul_result[31:0]  : src1);

  // Stall and unit controls are combinational so they rise/fall in the deciding cycle
  assign stallreq    = (!rst && (start_div || start_mul || div_wait || (in_mul && !flush && !mul_last)))
                       ? Stop : NoStop;
  assign div_start   = (!rst && div_wait) ? DivStart : DivStop;
  assign div_signed  = !rst && in_div && sign_q;
  assign div_annul   = !rst && in_div && flush;
  assign div_opdata1 = (!rst && in_div) ? opa_q : 32'd0;
  assign div_opdata2 = (!rst && in_div) ? opb_q : 32'd0;
  assign mul_signed  = !rst && in_mul && sign_q;
  assign mul_ina     = (!rst && in_mul) ? opa_q : 32'd0;
  assign mul_inb     = (!rst && in_mul) ? opb_q : 32'd0;

  hilo_reg u_hilo (
    .clk      (clk),
    .rst      (rst),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .hi       (hi_o),
    .lo       (lo_o)
  );

  logic unused_done;
  assign unused_done = in_done;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (MUL_LAT = 2).
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        ex_stall, flush;
  logic        stallreq, div_start, div_signed, div_annul;
  logic [31:0] div_opdata1, div_opdata2;
  logic        div_ready;
  logic [63:0] div_result;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic [31:0] hi_o, lo_o;

  int checks   = 0;
  int failures = 0;
  int cnt_s;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src1(src1), .src2(src2),
    .ex_stall(ex_stall), .flush(flush), .stallreq(stallreq),
    .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
    .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
    .div_ready(div_ready), .div_result(div_result),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
    .mul_result(mul_result), .hi_o(hi_o), .lo_o(lo_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = OP_NOP; src1 = 32'd0; src2 = 32'd0;
    ex_stall = 1'b0; flush = 1'b0; div_ready = 1'b0; div_result = 64'd0; mul_result = 64'd0;
    tick(); tick(); #1;
    chk1("rst_stallreq", stallreq, 1'b0);
    chk1("rst_div_start", div_start, 1'b0);
    chk32("rst_hi", hi_o, 32'd0);
    chk32("rst_lo", lo_o, 32'd0);
    chk32("rst_mul_ina", mul_ina, 32'd0);

    // MTHI then MTLO back to back
    tick(); rst = 1'b0; op_valid = 1'b1; op = OP_MTHI; src1 = 32'h12345678; #1;
    chk1("mthi_no_stall", stallreq, 1'b0);
`ifdef HILO_BYPASS_EN
    chk32("mthi_hi_same_cycle", hi_o, 32'h12345678);
`else
    chk32("mthi_hi_same_cycle", hi_o, 32'd0);
`endif
    tick(); op = OP_MTLO; src1 = 32'h9; #1;
    chk32("mthi_hi_next", hi_o, 32'h12345678);
`ifdef HILO_BYPASS_EN
    chk32("mtlo_lo_same_cycle", lo_o, 32'h9);
`else
    chk32("mtlo_lo_same_cycle", lo_o, 32'd0);
`endif
    tick(); op_valid = 1'b0; #1;
    chk32("mtlo_lo_next", lo_o, 32'h9);
    chk32("mtlo_hi_kept", hi_o, 32'h12345678);

    // DIVU 100/7, divider answers 33 cycles after issue
    cnt_s = 0;
    for (int k = 1; k <= 34; k++) begin
      tick();
      op_valid = 1'b1; op = OP_DIVU; src1 = 32'd100; src2 = 32'd7;
      div_ready  = (k == 34);
      div_result = (k == 34) ? {32'd2, 32'd14} : 64'hDEADBEEF_0BADF00D;
      #1;
      if (stallreq) cnt_s++;
      if (k == 2) begin
        chk1("divu_start", div_start, 1'b1);
        chk1("divu_signed", div_signed, 1'b0);
        chk32("divu_opdata1", div_opdata1, 32'd100);
        chk32("divu_opdata2", div_opdata2, 32'd7);
      end
      if (k == 34) chk1("divu_start_drop", div_start, 1'b0);
    end
    chk32("divu_stall_cycles", 32'(cnt_s), 32'd33);
    tick(); op_valid = 1'b0; div_ready = 1'b0; #1;
    chk32("divu_hi", hi_o, 32'd2);
    chk32("divu_lo", lo_o, 32'd14);
    chk1("divu_done_stall", stallreq, 1'b0);

    // MULT -2 * 3, result valid on the second MUL_RUN cycle
    tick(); op_valid = 1'b1; op = OP_MULT; src1 = 32'hFFFFFFFE; src2 = 32'd3; mul_result = 64'd0; #1;
    chk1("mult_issue_stall", stallreq, 1'b1);
    chk32("mult_idle_ina", mul_ina, 32'd0);
    tick(); mul_result = 64'h0BAD0BAD_0BAD0BAD; #1;
    chk1("mult_run_stall", stallreq, 1'b1);
    chk32("mult_ina", mul_ina, 32'hFFFFFFFE);
    chk32("mult_inb", mul_inb, 32'd3);
    chk1("mult_signed", mul_signed, 1'b1);
    tick(); mul_result = 64'hFFFFFFFF_FFFFFFFA; #1;
    chk1("mult_last_stall", stallreq, 1'b0);
    tick(); op_valid = 1'b0; mul_result = 64'd0; #1;
    chk32("mult_hi", hi_o, 32'hFFFFFFFF);
    chk32("mult_lo", lo_o, 32'hFFFFFFFA);
    chk32("mult_done_ina", mul_ina, 32'd0);

    // DIV flushed on its 5th cycle, coinciding with div_ready
    cnt_s = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      op_valid = 1'b1; op = OP_DIV; src1 = 32'd50; src2 = 32'd5;
      flush = (k == 5); div_ready = (k == 5); div_result = 64'h11111111_22222222;
      #1;
      if (div_annul) cnt_s++;
      if (k == 2) chk1("div_signed", div_signed, 1'b1);
      if (k == 5) begin
        chk1("flush_stall_drop", stallreq, 1'b0);
        chk1("flush_start_drop", div_start, 1'b0);
      end
    end
    tick(); op_valid = 1'b0; flush = 1'b0; div_ready = 1'b0; #1;
    if (div_annul) cnt_s++;
    chk32("flush_annul_pulses", 32'(cnt_s), 32'd1);
    chk32("flush_hi_kept", hi_o, 32'hFFFFFFFF);
    chk32("flush_lo_kept", lo_o, 32'hFFFFFFFA);
    chk1("flush_idle_start", div_start, 1'b0);

    // DIVU by zero finishing under a 3-cycle EX stall
    cnt_s = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      op_valid = (k <= 7); op = OP_DIVU; src1 = 32'd9; src2 = 32'd0;
      div_ready  = (k == 3);
      div_result = (k == 3) ? {32'd9, 32'hFFFFFFFF} : 64'h22222222_33333333;
      ex_stall   = (k >= 3) && (k <= 6);
      #1;
      if (k >= 4) begin
        if (div_start || stallreq) cnt_s++;
        chk32("done_hi_once", hi_o, 32'd9);
        chk32("done_lo_once", lo_o, 32'hFFFFFFFF);
      end
    end
    chk32("done_no_restart", 32'(cnt_s), 32'd0);

    // MULTU flushed on its final count
    tick(); op_valid = 1'b1; op = OP_MULTU; src1 = 32'd3; src2 = 32'd4; mul_result = 64'd0; #1;
    tick(); #1;
    chk1("multu_unsigned", mul_signed, 1'b0);
    tick(); flush = 1'b1; mul_result = 64'd12; #1;
    chk1("mflush_stall_drop", stallreq, 1'b0);
    tick(); flush = 1'b0; op_valid = 1'b0; mul_result = 64'd0; #1;
    chk32("mflush_hi_kept", hi_o, 32'd9);
    chk32("mflush_lo_kept", lo_o, 32'hFFFFFFFF);
    chk32("mflush_idle_ina", mul_ina, 32'd0);

    // Unknown op codes and a stalled MTHI are ignored
    tick(); op_valid = 1'b1; op = 3'd7; src1 = 32'hAAAA5555; #1;
    chk1("unk7_no_stall", stallreq, 1'b0);
    tick(); op = OP_NOP; #1;
    chk1("unk0_no_stall", stallreq, 1'b0);
    chk1("unk_no_div", div_start, 1'b0);
    chk32("unk_no_mul", mul_ina, 32'd0);
    tick(); op = OP_MTHI; src1 = 32'h55; ex_stall = 1'b1; #1;
    tick(); op_valid = 1'b0; ex_stall = 1'b0; #1;
    chk32("unk_hi_kept", hi_o, 32'd9);
    chk32("unk_lo_kept", lo_o, 32'hFFFFFFFF);

    // Reset in the middle of MUL_RUN
    tick(); op_valid = 1'b1; op = OP_MULT; src1 = 32'd5; src2 = 32'd6; mul_result = 64'd30; #1;
    tick(); rst = 1'b1; #1;
    chk1("rstmul_stall", stallreq, 1'b0);
    chk32("rstmul_ina", mul_ina, 32'd0);
    chk1("rstmul_signed", mul_signed, 1'b0);
    tick(); rst = 1'b0; op_valid = 1'b0; #1;
    chk32("rstmul_hi", hi_o, 32'd0);
    chk32("rstmul_lo", lo_o, 32'd0);
    chk1("rstmul_idle_stall", stallreq, 1'b0);
    chk32("rstmul_idle_ina", mul_ina, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
